// File: rtl/button_debouncer.sv
// Push-button debouncer: multi-flop synchronizer followed by a stability counter
// that accepts a new level only after STABLE_CYCLES consecutive differing samples.
`timescale 1ns/1ps
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 40,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic bounced_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   debounced_q, debounced_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bounced_i};
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Any sample matching the current output restarts qualification from zero.
  always_comb begin
    count_d     = '0;
    debounced_d = debounced_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    if (sync_s != debounced_q) begin
      if (count_q == CNT_MAX) begin
        debounced_d = sync_s;
        rise_d      = sync_s;
        fall_d      = ~sync_s;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      sync_q      <= '0;
      count_q     <= '0;
      debounced_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      count_q     <= count_d;
      debounced_q <= debounced_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign debounced_o = debounced_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random bounce
// trains, compared every cycle against a sliding-window reference model.
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int SC = 40;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic resetn;
  logic bounced_i;
  logic debounced_o, rise_o, fall_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int last_rise_cyc = -1;
  int last_fall_cyc = -1;

  // Reference model state
  bit raw_q[$];
  bit m_out, m_rise, m_fall;

  button_debouncer #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bounced_i  (bounced_i),
    .debounced_o(debounced_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o)
  );

  always #10 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Value seen by the filter at edge m: the raw input captured SS edges earlier,
  // zero for edges whose synchronizer content still comes from reset.
  function automatic bit used_at(input int m);
    if (m - SS >= 1) return raw_q[m - SS - 1];
    return 1'b0;
  endfunction

  // Output flips at edge k iff the last SC filter samples all differ from it.
  always @(posedge clock or posedge resetn) begin
    if (resetn) begin
      raw_q.delete();
      m_out  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      bit all_diff;
      int k;
      raw_q.push_back(bounced_i);
      k = raw_q.size();
      m_rise = 1'b0;
      m_fall = 1'b0;
      all_diff = 1'b1;
      for (int j = 0; j < SC; j++)
        if (used_at(k - j) == m_out) all_diff = 1'b0;
      if (all_diff) begin
        m_out  = ~m_out;
        m_rise = m_out;
        m_fall = ~m_out;
      end
    end
  end

  always @(negedge clock) begin
    check_eq("deb", int'(debounced_o), int'(m_out));
    check_eq("rise", int'(rise_o), int'(m_rise));
    check_eq("fall", int'(fall_o), int'(m_fall));
    if (rise_o) begin rise_cnt++; last_rise_cyc = cyc; end
    if (fall_o) begin fall_cnt++; last_fall_cyc = cyc; end
  end

  task automatic hold(input logic lvl, input int ns);
    bounced_i = lvl;
    #(ns);
  endtask

  // Waits (bounded) for the next output edge, checks its latency, then realigns
  // stimulus to 1 ns after a falling clock edge.
  task automatic wait_edge(input bit want_rise, input int mark, input int exp_lat,
                           input string tag);
    int r0, f0, n, lat;
    r0 = rise_cnt; f0 = fall_cnt; n = 0;
    while (((want_rise && rise_cnt == r0) || (!want_rise && fall_cnt == f0)) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) lat = -1;
    else lat = (want_rise ? last_rise_cyc : last_fall_cyc) - mark;
    check_eq(tag, lat, exp_lat);
    #1;
  endtask

  initial begin
    int r0, f0, mark, d;
    int widths[14] = '{100, 200, 100, 200, 300, 150, 120, 210, 330, 450, 270, 50, 100, 75};

    // Reset
    resetn = 1'b1;
    bounced_i = 1'b0;
    #100;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check_eq("rst_deb", int'(debounced_o), 0);
    check_eq("rst_cnt", int'(dut.count_q), 0);
    r0 = rise_cnt; f0 = fall_cnt;
    hold(1'b0, 200);
    check_eq("rst_pulses", rise_cnt + fall_cnt - r0 - f0, 0);

    // Bounce train
    r0 = rise_cnt; f0 = fall_cnt;
    for (int i = 0; i < 14; i++) hold((i % 2) == 0, widths[i]);
    hold(1'b0, 100);
    check_eq("bounce_deb", int'(debounced_o), 0);
    check_eq("bounce_pulses", rise_cnt + fall_cnt - r0 - f0, 0);

    // Stable high, then a rejected low glitch
    hold(1'b0, 855);
    r0 = rise_cnt;
    bounced_i = 1'b1;
    mark = cyc;
    wait_edge(1'b1, mark, SC + SS, "high_latency");
    hold(1'b1, 60);
    check_eq("high_rises", rise_cnt - r0, 1);
    f0 = fall_cnt;
    hold(1'b0, 100);
    hold(1'b1, 200);
    check_eq("glitch_deb", int'(debounced_o), 1);
    check_eq("glitch_falls", fall_cnt - f0, 0);

    // Stable low
    f0 = fall_cnt;
    bounced_i = 1'b0;
    mark = cyc;
    wait_edge(1'b0, mark, SC + SS, "low_latency");
    hold(1'b0, 150);
    check_eq("low_falls", fall_cnt - f0, 1);
    check_eq("low_deb", int'(debounced_o), 0);

    // Threshold: SC-1 samples rejected, SC samples accepted
    r0 = rise_cnt;
    @(negedge clock); bounced_i = 1'b1;
    repeat (SC - 1) @(negedge clock);
    bounced_i = 1'b0;
    repeat (SC + 5) @(negedge clock);
    check_eq("thr39_rises", rise_cnt - r0, 0);
    bounced_i = 1'b1;
    repeat (SC) @(negedge clock);
    bounced_i = 1'b0;
    repeat (5) @(negedge clock);
    check_eq("thr40_rises", rise_cnt - r0, 1);
    check_eq("thr40_deb", int'(debounced_o), 1);
    f0 = fall_cnt;
    repeat (SC - 6) @(negedge clock);
    bounced_i = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("thr_low39_deb", int'(debounced_o), 1);
    bounced_i = 1'b0;
    repeat (SC + 5) @(negedge clock);
    check_eq("thr_low40_falls", fall_cnt - f0, 1);
    check_eq("thr_low40_deb", int'(debounced_o), 0);
    #1;

    // Mid-count reset, then recovery with input still high
    hold(1'b1, 400);
    resetn = 1'b1;
    #1;
    check_eq("midrst_deb", int'(debounced_o), 0);
    check_eq("midrst_cnt", int'(dut.count_q), 0);
    #100;
    @(negedge clock);
    r0 = rise_cnt;
    resetn = 1'b0;
    mark = cyc;
    wait_edge(1'b1, mark, SC + SS, "midrst_latency");
    hold(1'b1, 100);
    check_eq("midrst_rises", rise_cnt - r0, 1);

    // Reset while the output is high clears it without a clock edge
    #3;
    resetn = 1'b1;
    #1;
    check_eq("hirst_deb", int'(debounced_o), 0);
    check_eq("hirst_rise", int'(rise_o), 0);
    #100;
    @(negedge clock);
    resetn = 1'b0;
    #1;

    // Random bounce trains with occasional long holds and resets
    for (int i = 0; i < 250; i++) begin
      if ($urandom % 4 == 0) d = $urandom_range(120, 300) * 5;
      else d = $urandom_range(1, 170) * 5;
      hold(1'($urandom % 2), d);
      if ($urandom % 40 == 0) begin
        resetn = 1'b1;
        #5;
        check_eq("rnd_rst_deb", int'(debounced_o), 0);
        #40;
        resetn = 1'b0;
      end
    end
    hold(1'b0, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
